// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding imem request, small decode queue, redirect flush.
// Optional IF_BYPASS_EN: forward a response straight to decode when the queue is empty.
module if_fetch_unit #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        redirect,
    output logic        pc_advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_fault,
    input  logic        id_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    state_t          state, state_nxt;
    entry_t          q_mem [DEPTH];
    entry_t          push_data, head;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     tag;
    logic            halted, halted_nxt;
    logic            push, pop, bypass, misaligned, q_free;

    assign misaligned = pc[1:0] != 2'b00;
    // No request is outstanding in IDLE/REQ, so free space is just the queue.
    assign q_free     = count < CW'(DEPTH);
    assign pop        = (count != '0) && id_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            halted <= 1'b0;
            tag    <= '0;
        end else begin
            state  <= state_nxt;
            halted <= halted_nxt;
            if (imem_req && imem_gnt && !redirect)
                tag <= pc;
        end
    end

    always_comb begin
        state_nxt  = state;
        halted_nxt = redirect ? 1'b0 : halted;
        imem_req   = 1'b0;
        imem_addr  = '0;
        pc_advance = 1'b0;
        push       = 1'b0;
        bypass     = 1'b0;
        push_data  = '{pc: pc, instr: NOP_INSTR, fault: 1'b1};
        case (state)
            IDLE: begin
                if (!redirect && !halted && q_free) begin
                    if (misaligned) begin
                        push       = 1'b1;
                        halted_nxt = 1'b1;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (misaligned) begin
                    if (!redirect && q_free) begin
                        push       = 1'b1;
                        halted_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end else begin
                    imem_req  = 1'b1;
                    imem_addr = pc;
                    if (imem_gnt) begin
                        pc_advance = !redirect;
                        state_nxt  = redirect ? DRAIN : WAIT;
                    end else if (redirect) begin
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT: begin
                // A response landing in the redirect cycle closes the transaction.
                if (redirect) begin
                    state_nxt = imem_rvalid ? IDLE : DRAIN;
                end else if (imem_rvalid) begin
                    push_data = '{pc: tag, instr: imem_rdata, fault: 1'b0};
`ifdef IF_BYPASS_EN
                    bypass = (count == '0) && id_ready;
`endif
                    push      = !bypass;
                    state_nxt = ((count < CW'(DEPTH - 1)) || pop) ? REQ : IDLE;
                end
            end
            DRAIN: begin
                if (imem_rvalid)
                    state_nxt = redirect ? IDLE : REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset; the count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !redirect)
            q_mem[wr_ptr] <= push_data;
    end

    always_comb begin
        head     = q_mem[rd_ptr];
        if_valid = 1'b0;
        if_instr = NOP_INSTR;
        if_pc    = '0;
        if_fault = 1'b0;
        if (count != '0) begin
            if_valid = 1'b1;
            if_instr = head.instr;
            if_pc    = head.pc;
            if_fault = head.fault;
        end else if (bypass) begin
            if_valid = 1'b1;
            if_instr = imem_rdata;
            if_pc    = tag;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed fetches, backpressure, redirects,
// misaligned fault and mid-transaction reset.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] tgt;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;
    logic        id_ready;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   gnt_cnt = 0;
    int   adv_cnt = 0;
    int   base;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .pc(pc), .redirect(redirect), .pc_advance(pc_advance),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc), .if_fault(if_fault), .id_ready(id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register seen by the fetch unit: redirect wins, else advance by 4.
    always @(posedge clk or negedge rst) begin
        if (!rst)            pc <= '0;
        else if (redirect)   pc <= tgt;
        else if (pc_advance) pc <= pc + 32'd4;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor samples just before each rising edge.
    initial forever begin
        @(negedge clk);
        #4;
        if (rst) begin
            if (imem_req && imem_gnt) gnt_cnt++;
            if (pc_advance) adv_cnt++;
            if (if_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_entry: got pc %h instr %h, expected no entry", if_pc, if_instr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("head_pc", if_pc, e.pc);
                    check("head_instr", if_instr, e.instr);
                    check("head_fault", {31'd0, if_fault}, {31'd0, e.fault});
                end
            end
        end
    end

    task automatic do_redirect(input logic [31:0] t);
        redirect = 1'b1;
        tgt      = t;
        tick();
        redirect = 1'b0;
    endtask

    // Waits for a request, checks its address and grants it (optionally with a redirect).
    task automatic grant(input logic [31:0] a, input bit with_rd, input logic [31:0] t);
        int n = 0;
        @(negedge clk);
        while (!imem_req && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            total++;
            bad++;
            $display("FAIL req_timeout: got no imem_req, expected request for %h", a);
            tick();
        end else begin
            check("imem_addr", imem_addr, a);
            #1;
            imem_gnt = 1'b1;
            if (with_rd) begin
                redirect = 1'b1;
                tgt      = t;
            end
            @(posedge clk);
            #1;
            imem_gnt = 1'b0;
            redirect = 1'b0;
        end
    endtask

    task automatic respond(input logic [31:0] d, input logic [31:0] tpc, input bit keep);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        if (keep) exp_q.push_back('{pc: tpc, instr: d, fault: 1'b0});
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_req"}, {31'd0, imem_req}, 32'd0);
        check({nm, "_addr"}, imem_addr, 32'd0);
        check({nm, "_adv"}, {31'd0, pc_advance}, 32'd0);
        check({nm, "_valid"}, {31'd0, if_valid}, 32'd0);
        check({nm, "_instr"}, if_instr, NOP);
        check({nm, "_pc"}, if_pc, 32'd0);
        check({nm, "_fault"}, {31'd0, if_fault}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; redirect = 1'b0; tgt = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b1;
        tick();
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst = 1'b1;

        // Single fetch at pc=0
        base = adv_cnt;
        grant(32'h0, 1'b0, 32'h0);
        respond(32'h0050_0093, 32'h0, 1'b1);
        @(negedge clk);
`ifdef IF_BYPASS_EN
        check("bypass_consumed", {31'd0, if_valid}, 32'd0);
`else
        check("lat_valid", {31'd0, if_valid}, 32'd1);
        check("lat_pc", if_pc, 32'h0);
        check("lat_instr", if_instr, 32'h0050_0093);
`endif
        check("adv_once", adv_cnt - base, 32'd1);
        tick();

        // Backpressure: two fetches fill the queue, then no requests
        id_ready = 1'b0;
        base = gnt_cnt;
        grant(32'h4, 1'b0, 32'h0);
        respond(32'h1111_0004, 32'h4, 1'b1);
        grant(32'h8, 1'b0, 32'h0);
        respond(32'h2222_0008, 32'h8, 1'b1);
        imem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_no_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        imem_gnt = 1'b0;
        check("full_grants", gnt_cnt - base, 32'd2);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        grant(32'hC, 1'b0, 32'h0);
        respond(32'h3333_000C, 32'hC, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("refull_no_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        check("refull_grants", gnt_cnt - base, 32'd3);
        id_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("resume_req", {31'd0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, 32'h10);
        tick();

        // Redirect while waiting for the 0x20 response
        do_redirect(32'h20);
        @(negedge clk);
        check("withdraw_req", {31'd0, imem_req}, 32'd0);
        grant(32'h20, 1'b0, 32'h0);
        do_redirect(32'h80);
        respond(32'hDEAD_0020, 32'h20, 1'b0);
        grant(32'h80, 1'b0, 32'h0);
        respond(32'h00A0_0113, 32'h80, 1'b1);
        tick();

        // Redirect coincident with grant
        do_redirect(32'h40);
        base = adv_cnt;
        grant(32'h40, 1'b1, 32'h60);
        @(negedge clk);
        check("drain_no_req", {31'd0, imem_req}, 32'd0);
        check("gnt_redirect_no_adv", adv_cnt - base, 32'd0);
        tick();
        respond(32'hBAD0_0040, 32'h40, 1'b0);
        grant(32'h60, 1'b0, 32'h0);
        respond(32'h00C0_0193, 32'h60, 1'b1);
        tick();
        check("post_drain_adv", adv_cnt - base, 32'd1);

        // Misaligned pc produces a fault entry and stalls fetch
        id_ready = 1'b0;
        do_redirect(32'h102);
        exp_q.push_back('{pc: 32'h102, instr: NOP, fault: 1'b1});
        tick();
        @(negedge clk);
        check("fault_valid", {31'd0, if_valid}, 32'd1);
        check("fault_flag", {31'd0, if_fault}, 32'd1);
        check("fault_pc", if_pc, 32'h102);
        check("fault_instr", if_instr, NOP);
        check("fault_no_req", {31'd0, imem_req}, 32'd0);
        base = gnt_cnt;
        tick();
        id_ready = 1'b1;
        imem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fault_stall_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        imem_gnt = 1'b0;
        check("fault_stall_grants", gnt_cnt - base, 32'd0);
        do_redirect(32'h200);
        grant(32'h200, 1'b0, 32'h0);
        respond(32'h0000_0513, 32'h200, 1'b1);
        tick();

        // Reset in the middle of an outstanding fetch
        do_redirect(32'h100);
        grant(32'h100, 1'b0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        tick();
        rst = 1'b1;
        respond(32'h0010_0100, 32'h100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_rvalid_ignored", {31'd0, if_valid}, 32'd0);
            tick();
        end

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly downstream of the PC register. It takes the current PC, issues word requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned instructions in a small queue for decode. It also tells the next-PC logic when the PC may advance. A single-cycle redirect from branch/jump resolution flushes all in-flight fetch state.

Parameters:
DEPTH, 2, instruction queue entries (power of 2, >=2)
NOP_INSTR, 32'h0000_0013, value driven on if_instr while the queue is empty (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
pc  in  32  current PC from the PC register
redirect  in  1  branch/jump taken; PC register loads target on this same edge
pc_advance  out  1  next-PC logic selects pc+4 at next edge when 1, holds pc when 0 (ignored when redirect=1)
imem_req  out  1  memory request
imem_addr  out  32  request word address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  response instruction
if_valid  out  1  queue head valid toward decode
if_instr  out  32  queue head instruction
if_pc  out  32  PC of queue head
if_fault  out  1  queue head is a misaligned-fetch fault entry
id_ready  in  1  decode accepts head when if_valid=1

Behaviour:
Reset (rst=0, async): state=IDLE, queue empty, outstanding=0, imem_req=0, imem_addr=0, pc_advance=0, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_fault=0.

States:
- IDLE: go to REQ when free slots exist (count + outstanding < DEPTH) and redirect=0.
- REQ: imem_req=1, imem_addr=pc. Hold both stable until imem_gnt. On req&gnt: pc_advance=1 that cycle, latch pc into a tag register, outstanding=1, go to WAIT.
- WAIT: on imem_rvalid, push {tag, imem_rdata, fault=0}, outstanding=0, then REQ if slots remain, else IDLE.
- DRAIN: a granted request was killed by redirect. On imem_rvalid, discard the data and go to REQ (or IDLE if redirect=1 again). Never push in DRAIN.

Limits and alignment:
- At most 1 outstanding request.
- Misaligned pc (pc[1:0]!=0) in IDLE/REQ: no memory request. Push {pc, NOP_INSTR, fault=1} and pulse pc_advance=0. Stay in IDLE until redirect. Further fetch after a fault requires redirect.

Redirect (highest priority, any state):
- Queue cleared the same edge.
- REQ with no grant: request withdrawn (imem_req=0 next cycle), go to IDLE.
- WAIT, or grant in the redirect cycle: go to DRAIN.
- A grant coinciding with redirect produces no pc_advance effect.

Queue:
- Pop when if_valid & id_ready.
- Simultaneous push and pop on a full queue is legal; count is unchanged.
- if_instr/if_pc/if_fault reflect the head combinationally from registered storage.

Latency:
- Grant at cycle g, rvalid at cycle r>g: if_valid=1 at r+1.
- Back-to-back throughput with 1-cycle memory and id_ready=1: one instruction per 2 cycles (REQ, WAIT).

Optional Feature:
IF_BYPASS_EN
- Defined: when the queue is empty, in WAIT, imem_rvalid=1 and id_ready=1, the response is forwarded combinationally to if_valid/if_instr/if_pc that cycle and not pushed. REQ may be re-entered the next cycle, giving latency 0 after rvalid.
- Undefined: all responses go through the queue, with latency +1.
- DRAIN responses are never bypassed.

Test Plan:
- Reset mid-WAIT (pc=0x100 granted, rst pulsed low before rvalid): all outputs return to reset values immediately; the later rvalid is ignored; if_valid stays 0.
- pc=0x0, gnt same cycle, rvalid 1 cycle later with 0x00500093, id_ready=1: pc_advance pulses once; if_valid=1, if_pc=0x0, if_instr=0x00500093 one cycle after rvalid (same cycle with IF_BYPASS_EN).
- id_ready=0, DEPTH=2, four fetches offered: exactly 2 grants, then imem_req=0. After one pop, exactly one further request issues.
- Redirect in WAIT for pc=0x20, target 0x80: the pending response is discarded, the next imem_addr=0x80, and the first if_pc after the redirect is 0x80 with no 0x20 entry ever visible.
- pc=0x102 (misaligned): no imem_req; if_valid=1, if_fault=1, if_pc=0x102, if_instr=0x00000013. No further requests until redirect to 0x200, after which fetch resumes at 0x200.
- Redirect coincident with imem_gnt at pc=0x40: FSM enters DRAIN, the returned data is dropped, and the next fetch address is the new pc.
